// File: rtl/toggle_sched.sv
// Round-robin scheduler granting one T flip-flop toggle at a time, with clear-all and relay cooldown.
// Latency: request sampled at edge k -> ack/t_out pulse during cycle k+1; grants spaced >= GAP+1 cycles.
// Backpressure: req is a level held until ack; req/clr are ignored while busy (COOL), losers wait in RR order.
module toggle_sched #(
  parameter int N_REQ = 4,
  parameter int N_OUT = 4,
  parameter int OUT_W = 2,
  parameter int GAP   = 8,
  parameter int GAP_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*OUT_W-1:0] sel,
  input  logic                   clr,
  output logic [N_REQ-1:0]       ack,
  output logic [N_OUT-1:0]       t_out,
  output logic [N_OUT-1:0]       q,
  output logic                   busy,
  output logic                   err
);

  localparam int RR_W = $clog2(N_REQ);

  typedef enum logic {IDLE, COOL} state_t;

  state_t           state, state_d;
  logic [GAP_W-1:0] cnt, cnt_d;
  logic [RR_W-1:0]  rr_ptr, rr_d;
  logic [N_REQ-1:0] ack_d;
  logic [N_OUT-1:0] t_d, q_d;
  logic             busy_d, err_d;

  logic [RR_W-1:0]  win;
  logic             found;
  int               idx;
  logic [OUT_W-1:0] sel_w;
  logic [N_OUT-1:0] sel_oh;
  logic             in_range;

  // Round-robin search: first requester at or above rr_ptr, wrapping.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(rr_ptr) + i) % N_REQ;
      if (!found && req[idx[RR_W-1:0]]) begin
        found = 1'b1;
        win   = idx[RR_W-1:0];
      end
    end
  end

  assign sel_w    = sel[int'(win)*OUT_W +: OUT_W];
  assign sel_oh   = N_OUT'(1) << sel_w;
  assign in_range = (int'(sel_w) < N_OUT);

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    rr_d    = rr_ptr;
    ack_d   = '0;
    t_d     = '0;
    q_d     = q;
    err_d   = 1'b0;
    busy_d  = 1'b0;
    case (state)
      IDLE: begin
        if (clr) begin
          // Pulse only the outputs currently on so the bank ends all-off.
          t_d     = q;
          q_d     = '0;
          state_d = COOL;
          cnt_d   = GAP_W'(GAP - 1);
        end else if (found) begin
          ack_d   = N_REQ'(1) << win;
          rr_d    = (win == RR_W'(N_REQ - 1)) ? '0 : win + 1'b1;
          state_d = COOL;
          cnt_d   = GAP_W'(GAP - 1);
          if (in_range) begin
            t_d = sel_oh;
            q_d = q ^ sel_oh;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      COOL: begin
        if (cnt == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == COOL);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      rr_ptr <= '0;
      ack    <= '0;
      t_out  <= '0;
      q      <= '0;
      busy   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      rr_ptr <= rr_d;
      ack    <= ack_d;
      t_out  <= t_d;
      q      <= q_d;
      busy   <= busy_d;
      err    <= err_d;
    end
  end

endmodule
